// File: rtl/spi_pkg.sv
// Shared types and elaboration helpers for the SPI MOSI arbiter.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 32'd1 : 32'($clog2(n));
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit params_ok(input int unsigned num_req, input int unsigned data_w,
                                   input int unsigned clk_div, input int unsigned gap_cyc);
    return (num_req >= 2) && (num_req <= 8) && (data_w >= 4) && (data_w <= 32) &&
           (clk_div >= 1) && (gap_cyc >= 1);
  endfunction

endpackage

// File: rtl/spi_mosi_arbiter_if.sv
// Requester-side and SPI-pin signals of the MOSI arbiter.
interface spi_mosi_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 12
);
  import spi_pkg::*;

  localparam int unsigned ID_W = clog2_min1(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic                      done;
  logic [ID_W-1:0]           done_id;
  logic                      sclk;
  logic                      mosi;
  logic [NUM_REQ-1:0]        ss;

  modport master (
    input  req, data,
    output grant, busy, done, done_id, sclk, mosi, ss
  );

  modport slave (
    output req, data,
    input  grant, busy, done, done_id, sclk, mosi, ss
  );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module spi_rr_arbiter
  import spi_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic               o_valid_c,
  output logic [ID_W-1:0]    o_idx_c,
  output logic [NUM_REQ-1:0] o_onehot_c
);

  logic [ID_W-1:0] w_cand;

  always_comb begin
    o_valid_c = 1'b0;
    o_idx_c   = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = ID_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!o_valid_c && i_req[w_cand]) begin
        o_valid_c = 1'b1;
        o_idx_c   = w_cand;
      end
    end
  end

  assign o_onehot_c = o_valid_c ? (NUM_REQ'(1) << o_idx_c) : '0;

endmodule

// File: rtl/spi_mosi_arbiter.sv
// Round-robin sharing of one SPI mode-0 MOSI channel; one active-low select per requester.
module spi_mosi_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned CLK_DIV = 10,
  parameter int unsigned GAP_CYC = CLK_DIV
) (
  input logic                clk,
  input logic                rst,
  spi_mosi_arbiter_if.master bus
);

  localparam int unsigned ID_W   = clog2_min1(NUM_REQ);
  localparam int unsigned CNT_W  = clog2_min1(max_u(CLK_DIV, GAP_CYC));
  localparam int unsigned RISE_W = clog2_min1(DATA_W + 1);

  if (!params_ok(NUM_REQ, DATA_W, CLK_DIV, GAP_CYC)) begin : g_bad_params
    $error("spi_mosi_arbiter: parameter out of range");
  end

  state_t             r_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [RISE_W-1:0]  r_rises;
  logic [DATA_W-2:0]  r_shift;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_busy;
  logic               r_done;
  logic [ID_W-1:0]    r_done_id;
  logic               r_sclk;
  logic               r_mosi;
  logic [NUM_REQ-1:0] r_ss;

  logic               w_valid;
  logic [ID_W-1:0]    w_idx;
  logic [NUM_REQ-1:0] w_onehot;
  logic [DATA_W-1:0]  w_words [NUM_REQ];
  logic [DATA_W-1:0]  w_word;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign w_words[g] = bus.data[g*DATA_W +: DATA_W];
  end
  assign w_word = w_words[w_idx];

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req      (bus.req),
    .i_ptr      (r_rr_ptr),
    .o_valid_c  (w_valid),
    .o_idx_c    (w_idx),
    .o_onehot_c (w_onehot)
  );

  // r_cnt is the sclk half-period divider in SHIFT and the idle counter in GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_rises   <= '0;
      r_shift   <= '0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_ss      <= '1;
    end else begin
      r_grant <= '0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_grant  <= w_onehot;
            r_ss     <= ~w_onehot;
            r_mosi   <= w_word[DATA_W-1];
            r_shift  <= w_word[DATA_W-2:0];
            r_idx    <= w_idx;
            r_rr_ptr <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_rises  <= '0;
            r_sclk   <= 1'b0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
            r_cnt <= '0;
            if (!r_sclk) begin
              r_sclk  <= 1'b1;
              r_rises <= r_rises + 1'b1;
            end else begin
              r_sclk <= 1'b0;
              // The falling edge after the last sample closes the frame.
              if (r_rises == RISE_W'(DATA_W)) begin
                r_ss      <= '1;
                r_mosi    <= 1'b0;
                r_done    <= 1'b1;
                r_done_id <= r_idx;
                r_state   <= GAP;
              end else begin
                r_mosi  <= r_shift[DATA_W-2];
                r_shift <= {r_shift[DATA_W-3:0], 1'b0};
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GAP: begin
          if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.grant   = r_grant;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;
  assign bus.sclk    = r_sclk;
  assign bus.mosi    = r_mosi;
  assign bus.ss      = r_ss;

endmodule

// File: tb/tb_spi_mosi_arbiter.sv
// Randomized self-checking bench for spi_mosi_arbiter with a round-robin/SPI reference model.
`timescale 1ns/1ps
module tb_spi_mosi_arbiter;

  localparam int NR     = 4;
  localparam int DW     = 12;
  localparam int CD     = 10;
  localparam int GC     = 10;
  localparam int SS_LEN = 2 * CD * DW;
  localparam int TXN    = SS_LEN + GC + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  spi_mosi_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();
  spi_mosi_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CLK_DIV(CD), .GAP_CYC(GC)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  spi_mosi_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus2 ();
  spi_mosi_arbiter #(.NUM_REQ(4), .DATA_W(8), .CLK_DIV(2)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  // ---------------- passive observer of the SPI pins of dut ----------------
  typedef struct {
    int          id;
    logic [31:0] bits;
    int          sslen;
    int          rises;
    logic [NR-1:0] sel;
  } rec_t;

  rec_t q_rec[$];
  int   q_grant[$];
  int   q_gap[$];
  int   mon_cyc = 0, last_end = -1, ss_len = 0, rises = 0;
  int   multi_ss = 0, stray_sclk = 0, bad_onehot = 0, aborts = 0, sel_change = 0;
  bit   in_txn = 1'b0;
  logic prev_sclk = 1'b0;
  logic [31:0]   bits = '0;
  logic [NR-1:0] sel = '0, ss_seen = '0, mon_act;

  always @(negedge clk) begin
    mon_cyc++;
    if (rst) begin
      if (in_txn) aborts++;
      in_txn = 1'b0; ss_len = 0; rises = 0; last_end = -1; prev_sclk = 1'b0;
    end else begin
      if (bus.grant !== '0) begin
        if ($countones(bus.grant) != 1) bad_onehot++;
        for (int i = 0; i < NR; i++) if (bus.grant[i]) q_grant.push_back(i);
      end
      mon_act = ~bus.ss;
      if ($countones(mon_act) > 1) multi_ss++;
      ss_seen |= mon_act;
      if (mon_act != '0) begin
        if (!in_txn) begin
          in_txn = 1'b1; sel = mon_act; ss_len = 0; rises = 0; bits = '0;
          if (last_end >= 0) q_gap.push_back(mon_cyc - last_end);
        end
        if (mon_act != sel) sel_change++;
        ss_len++;
        if (bus.sclk && !prev_sclk) begin
          bits = {bits[30:0], bus.mosi};
          rises++;
        end
      end else begin
        if (bus.sclk) stray_sclk++;
        if (bus.done) begin
          q_rec.push_back('{int'(bus.done_id), bits, ss_len, rises, sel});
          in_txn = 1'b0; last_end = mon_cyc;
        end else if (in_txn) begin
          aborts++; in_txn = 1'b0; last_end = -1;
        end
      end
      prev_sclk = bus.sclk;
    end
  end

  // ---------------- reference model and stimulus helpers ----------------
  int m_ptr = 0;
  logic [DW-1:0] words [NR];

  function automatic int rr_pick(input logic [NR-1:0] m, input int ptr);
    for (int k = 0; k < NR; k++) if (m[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR*DW-1:0] pack_words(input logic [DW-1:0] w [NR]);
    logic [NR*DW-1:0] d;
    for (int i = 0; i < NR; i++) d[i*DW +: DW] = w[i];
    return d;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; bus.req = '0; bus2.req = '0;
    repeat (3) tick();
    q_rec.delete(); q_grant.delete(); q_gap.delete();
    multi_ss = 0; stray_sclk = 0; bad_onehot = 0; aborts = 0; sel_change = 0; ss_seen = '0;
    m_ptr = 0;
    for (int i = 0; i < NR; i++) words[i] = DW'($urandom);
    bus.data = pack_words(words);
    rst = 1'b0;
  endtask

  task automatic wait_grants(input int n, input int budget, output bit to);
    int b = budget;
    while (q_grant.size() < n && b > 0) begin tick(); b--; end
    to = (q_grant.size() < n);
  endtask

  task automatic wait_recs(input int n, input int budget, output bit to);
    int b = budget;
    while (q_rec.size() < n && b > 0) begin tick(); b--; end
    to = (q_rec.size() < n);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; bus.req = '0; bus.data = '0; bus2.req = '0; bus2.data = '0;
    tick(); tick();
    total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", bus.grant); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.done_id !== 2'd0) begin bad++; $display("FAIL reset_done_id got=%0d exp=0", bus.done_id); end
    total++; if (bus.sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b exp=0", bus.sclk); end
    total++; if (bus.mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b exp=0", bus.mosi); end
    total++; if (bus.ss !== 4'b1111) begin bad++; $display("FAIL reset_ss got=%b exp=1111", bus.ss); end
    total++; if (bus2.ss !== 4'b1111) begin bad++; $display("FAIL reset_ss_small got=%b exp=1111", bus2.ss); end
    rst = 1'b0;
    repeat (5) tick();
    total++; if (bus.ss !== 4'b1111 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL idle_no_req ss=%b busy=%b exp ss=1111 busy=0", bus.ss, bus.busy);
    end
  endtask

  task automatic test_single();
    bit to;
    rec_t r;
    apply_reset();
    words[2] = 12'hA5C;
    bus.data = pack_words(words);
    bus.req  = 4'b0100;
    wait_grants(1, 20, to);
    total++; if (to) begin bad++; $display("FAIL single_grant_timeout got=none exp=grant"); end
    bus.req = '0;
    total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b exp=0100", bus.grant); end
    total++; if (bus.ss !== 4'b1011 || bus.busy !== 1'b1 || bus.mosi !== 1'b1) begin
      bad++; $display("FAIL single_start ss=%b busy=%b mosi=%b exp ss=1011 busy=1 mosi=1", bus.ss, bus.busy, bus.mosi);
    end
    tick();
    total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL single_grant_pulse got=%b exp=0000", bus.grant); end
    wait_recs(1, SS_LEN + 50, to);
    total++; if (to) begin bad++; $display("FAIL single_done_timeout got=none exp=done"); end
    else begin
      r = q_rec[0];
      total++; if (r.id != 2) begin bad++; $display("FAIL single_done_id got=%0d exp=2", r.id); end
      total++; if (r.bits[DW-1:0] !== 12'hA5C) begin bad++; $display("FAIL single_bits got=%h exp=a5c", r.bits[DW-1:0]); end
      total++; if (r.sslen != SS_LEN) begin bad++; $display("FAIL single_ss_len got=%0d exp=%0d", r.sslen, SS_LEN); end
      total++; if (r.rises != DW) begin bad++; $display("FAIL single_rises got=%0d exp=%0d", r.rises, DW); end
      total++; if (bus.ss !== 4'b1111 || bus.sclk !== 1'b0 || bus.mosi !== 1'b0 || bus.busy !== 1'b1) begin
        bad++; $display("FAIL single_end ss=%b sclk=%b mosi=%b busy=%b exp 1111/0/0/1", bus.ss, bus.sclk, bus.mosi, bus.busy);
      end
      repeat (GC - 1) tick();
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_gap got=%b exp=1", bus.busy); end
      tick();
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_drop got=%b exp=0", bus.busy); end
    end
    repeat (20) tick();
    total++; if (q_grant.size() != 1) begin bad++; $display("FAIL single_grant_count got=%0d exp=1", q_grant.size()); end
  endtask

  task automatic test_all_req();
    bit to;
    int exp;
    apply_reset();
    bus.req = 4'b1111;
    wait_recs(5, 5 * TXN + 50, to);
    bus.req = '0;
    total++; if (to) begin bad++; $display("FAIL all_timeout got=%0d exp=5 transfers", q_rec.size()); end
    else begin
      for (int k = 0; k < 5; k++) begin
        exp = rr_pick(4'b1111, m_ptr);
        m_ptr = (exp + 1) % NR;
        total++; if (q_rec[k].id != exp || q_rec[k].bits[DW-1:0] !== words[exp] || q_rec[k].sslen != SS_LEN) begin
          bad++; $display("FAIL all_txn%0d id=%0d bits=%h len=%0d exp id=%0d bits=%h len=%0d",
                          k, q_rec[k].id, q_rec[k].bits[DW-1:0], q_rec[k].sslen, exp, words[exp], SS_LEN);
        end
      end
      for (int k = 0; k < 4; k++) begin
        total++; if (k >= q_gap.size() || q_gap[k] != GC + 1) begin
          bad++; $display("FAIL all_gap%0d got=%0d exp=%0d", k, (k < q_gap.size()) ? q_gap[k] : -1, GC + 1);
        end
      end
    end
    repeat (2 * GC) tick();
    total++; if (multi_ss != 0 || bad_onehot != 0 || sel_change != 0) begin
      bad++; $display("FAIL all_exclusive multi=%0d onehot=%0d selchg=%0d exp 0/0/0", multi_ss, bad_onehot, sel_change);
    end
    total++; if (q_grant.size() != 5) begin bad++; $display("FAIL all_grant_count got=%0d exp=5", q_grant.size()); end
  endtask

  task automatic test_fairness();
    bit to;
    int exp;
    apply_reset();
    bus.req = 4'b1001;
    wait_recs(4, 4 * TXN + 50, to);
    bus.req = '0;
    total++; if (to) begin bad++; $display("FAIL fair_timeout got=%0d exp=4 transfers", q_rec.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        exp = rr_pick(4'b1001, m_ptr);
        m_ptr = (exp + 1) % NR;
        total++; if (q_rec[k].id != exp) begin bad++; $display("FAIL fair_txn%0d got=%0d exp=%0d", k, q_rec[k].id, exp); end
      end
    end
    repeat (2 * GC) tick();
    total++; if (ss_seen !== 4'b1001) begin bad++; $display("FAIL fair_ss_seen got=%b exp=1001", ss_seen); end
  endtask

  task automatic test_reset_abort();
    bit to;
    int b = 400;
    apply_reset();
    bus.req = 4'b0010;
    wait_grants(1, 20, to);
    bus.req = '0;
    while (rises < 5 && b > 0) begin tick(); b--; end
    total++; if (rises < 5) begin bad++; $display("FAIL abort_rise_timeout got=%0d exp=5", rises); end
    rst = 1'b1;
    tick();
    total++; if (bus.ss !== 4'b1111 || bus.sclk !== 1'b0 || bus.mosi !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL abort_state ss=%b sclk=%b mosi=%b busy=%b done=%b exp 1111/0/0/0/0",
                      bus.ss, bus.sclk, bus.mosi, bus.busy, bus.done);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    total++; if (q_rec.size() != 0 || aborts != 1) begin
      bad++; $display("FAIL abort_no_done recs=%0d aborts=%0d exp 0/1", q_rec.size(), aborts);
    end
    q_grant.delete();
    bus.req = 4'b0011;
    wait_grants(1, 20, to);
    bus.req = '0;
    total++; if (to || q_grant[0] != 0) begin
      bad++; $display("FAIL abort_ptr_reset got=%0d exp=0", to ? -1 : q_grant[0]);
    end
    wait_recs(1, SS_LEN + 50, to);
    total++; if (to || q_rec[0].id != 0 || q_rec[0].bits[DW-1:0] !== words[0]) begin
      bad++; $display("FAIL abort_next_txn recs=%0d exp id=0 bits=%h", q_rec.size(), words[0]);
    end
    total++; if (stray_sclk != 0) begin bad++; $display("FAIL abort_stray_sclk got=%0d exp=0", stray_sclk); end
  endtask

  task automatic test_drop_req();
    bit to;
    apply_reset();
    bus.req = 4'b0001;
    wait_grants(1, 20, to);
    bus.req = '0;
    repeat (30) tick();
    bus.req = 4'b0100;
    repeat (3) tick();
    bus.req = '0;
    wait_recs(1, SS_LEN + 50, to);
    repeat (GC + 20) tick();
    total++; if (to || q_rec[0].id != 0 || q_rec[0].bits[DW-1:0] !== words[0]) begin
      bad++; $display("FAIL drop_first_txn recs=%0d exp id=0 bits=%h", q_rec.size(), words[0]);
    end
    total++; if (q_grant.size() != 1) begin bad++; $display("FAIL drop_grant_count got=%0d exp=1", q_grant.size()); end
    total++; if (ss_seen !== 4'b0001) begin bad++; $display("FAIL drop_ss_seen got=%b exp=0001", ss_seen); end
  endtask

  task automatic test_random();
    bit to;
    int got, exp;
    logic [NR-1:0] req_v;
    logic [DW-1:0] exp_word;
    rec_t r;
    apply_reset();
    req_v = NR'($urandom_range(1, 15));
    bus.req = req_v;
    for (int t = 0; t < 10; t++) begin
      wait_grants(1, TXN + 20, to);
      total++; if (to) begin bad++; $display("FAIL rand%0d_grant_timeout req=%b", t, req_v); break; end
      got = q_grant.pop_front();
      exp = rr_pick(req_v, m_ptr);
      total++; if (got != exp) begin bad++; $display("FAIL rand%0d_grant got=%0d exp=%0d req=%b", t, got, exp, req_v); end
      exp_word = words[exp];
      m_ptr = (exp + 1) % NR;
      // Post-grant churn: fresh word for the served requester, random re-request and new arrivals.
      words[exp] = DW'($urandom);
      bus.data   = pack_words(words);
      req_v[exp] = 1'($urandom_range(0, 1));
      req_v     |= NR'($urandom_range(0, 15)) & NR'($urandom_range(0, 15));
      if (req_v == '0) req_v[$urandom_range(0, NR - 1)] = 1'b1;
      bus.req = req_v;
      wait_recs(1, SS_LEN + 50, to);
      total++; if (to) begin bad++; $display("FAIL rand%0d_done_timeout exp id=%0d", t, exp); break; end
      r = q_rec.pop_front();
      total++; if (r.id != exp || r.bits[DW-1:0] !== exp_word || r.sslen != SS_LEN || r.rises != DW) begin
        bad++; $display("FAIL rand%0d_txn id=%0d bits=%h len=%0d rises=%0d exp id=%0d bits=%h len=%0d rises=%0d",
                        t, r.id, r.bits[DW-1:0], r.sslen, r.rises, exp, exp_word, SS_LEN, DW);
      end
    end
    bus.req = '0;
    repeat (2 * GC) tick();
    total++; if (multi_ss != 0 || bad_onehot != 0) begin
      bad++; $display("FAIL rand_exclusive multi=%0d onehot=%0d exp 0/0", multi_ss, bad_onehot);
    end
  endtask

  task automatic test_small_config();
    logic [7:0] got_bits = '0;
    logic       p_sclk = 1'b0;
    int  low = 0, nr = 0, r0 = -1, r1 = -1, other = 0;
    bit  seen_done = 1'b0;
    apply_reset();
    bus2.data = {8'h3C, 8'h5A, 8'hC3, 8'h81};
    bus2.req  = 4'b0001;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      tick();
      if (bus2.grant[0]) bus2.req = '0;
      if (bus2.ss[3:1] !== 3'b111) other++;
      if (bus2.ss[0] === 1'b0) begin
        low++;
        if (bus2.sclk && !p_sclk) begin
          got_bits = {got_bits[6:0], bus2.mosi};
          if (nr == 0) r0 = c;
          if (nr == 1) r1 = c;
          nr++;
        end
      end
      if (bus2.done) begin
        seen_done = 1'b1;
        total++; if (bus2.done_id !== 2'd0) begin bad++; $display("FAIL small_done_id got=%0d exp=0", bus2.done_id); end
      end
      p_sclk = bus2.sclk;
    end
    total++; if (!seen_done) begin bad++; $display("FAIL small_done_timeout got=none exp=done"); end
    total++; if (low != 32) begin bad++; $display("FAIL small_ss_len got=%0d exp=32", low); end
    total++; if (got_bits !== 8'h81 || nr != 8) begin bad++; $display("FAIL small_bits got=%h/%0d exp=81/8", got_bits, nr); end
    total++; if (r1 - r0 != 4) begin bad++; $display("FAIL small_sclk_period got=%0d exp=4", r1 - r0); end
    total++; if (other != 0) begin bad++; $display("FAIL small_other_ss got=%0d exp=0", other); end
  endtask

  initial begin
    bus.req = '0; bus.data = '0; bus2.req = '0; bus2.data = '0;
    test_reset();
    test_single();
    test_all_req();
    test_fairness();
    test_reset_abort();
    test_drop_req();
    test_random();
    test_small_config();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
